// File: rtl/debounce_multi.sv
// N-channel push-button debouncer: 2-flop synchroniser, saturating stability counter,
// registered level and press/release pulses. Define LONG_PRESS_EN for long-press detection.
module debounce_multi #(
  parameter int N_CH         = 4,
  parameter int DELAY_COUNTS = 2500,
  parameter int HOLD_COUNTS  = 50000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] button_pressed,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic            any_pressed,
  output logic [N_CH-1:0] long_press
);

  localparam int CNT_W  = $clog2(DELAY_COUNTS + 1);
  localparam int HOLD_W = $clog2(HOLD_COUNTS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DELAY_COUNTS);

  logic [N_CH-1:0]  sync1;
  logic [N_CH-1:0]  sync2;
  logic [N_CH-1:0]  prev;
  logic [CNT_W-1:0] count [N_CH];
  logic [N_CH-1:0]  settle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // A channel settles once its synchronised input has matched for DELAY_COUNTS+1 compares.
  always_comb begin
    settle = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      settle[ch] = (sync2[ch] == prev[ch]) && (count[ch] == CNT_MAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        count[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if (sync2[ch] != prev[ch]) begin
          count[ch] <= '0;
        end else if (count[ch] != CNT_MAX) begin
          count[ch] <= count[ch] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      button_pressed <= '0;
      press_pulse    <= '0;
      release_pulse  <= '0;
    end else begin
      press_pulse   <= settle & prev & ~button_pressed;
      release_pulse <= settle & ~prev & button_pressed;
      for (int ch = 0; ch < N_CH; ch++) begin
        if (settle[ch]) begin
          button_pressed[ch] <= prev[ch];
        end
      end
    end
  end

  assign any_pressed = |button_pressed;

`ifdef LONG_PRESS_EN
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_COUNTS);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_COUNTS - 1);

  logic [HOLD_W-1:0] hold [N_CH];

  // Hold counter saturates, so long_press fires only once per press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      long_press <= '0;
      for (int ch = 0; ch < N_CH; ch++) begin
        hold[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < N_CH; ch++) begin
        long_press[ch] <= button_pressed[ch] && (hold[ch] == HOLD_PRE);
        if (!button_pressed[ch]) begin
          hold[ch] <= '0;
        end else if (hold[ch] != HOLD_MAX) begin
          hold[ch] <= hold[ch] + 1'b1;
        end
      end
    end
  end
`else
  logic [HOLD_W-1:0] unused_hold;
  assign unused_hold = HOLD_W'(HOLD_COUNTS);
  assign long_press  = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: window-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations (honours LONG_PRESS_EN).
module tb_debounce_multi;

  localparam int N = 4;
  localparam int D = 4;
  localparam int H = 20;
`ifdef LONG_PRESS_EN
  localparam logic [3:0] LONG_EXP = 4'b0101;
`else
  localparam logic [3:0] LONG_EXP = 4'b0000;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] button = '0;
  logic [N-1:0] button_pressed;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;
  logic         any_pressed;
  logic [N-1:0] long_press;

  int checks_total  = 0;
  int checks_passed = 0;

  debounce_multi #(
    .N_CH(N),
    .DELAY_COUNTS(D),
    .HOLD_COUNTS(H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .button(button),
    .button_pressed(button_pressed),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .any_pressed(any_pressed),
    .long_press(long_press)
  );

  always #5 clk = ~clk;

  // Model: raw samples per edge; level takes r[k-2] when r[k-D-3..k-2] all agree.
  bit           rq [N][$];
  int           k;
  int           hi_run [N];
  logic [N-1:0] m_level, m_press, m_release, m_long;
  logic         m_ready = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < N; ch++) begin
        rq[ch].delete();
        repeat (3) rq[ch].push_back(1'b0);
        hi_run[ch] = 0;
      end
      k = 0;
      m_level = '0; m_press = '0; m_release = '0; m_long = '0;
      m_ready = 1'b1;
    end else begin
      k++;
      for (int ch = 0; ch < N; ch++) begin
        bit stable;
        bit old;
        rq[ch].push_back(button[ch]);
        stable = (k >= D + 1);
        if (stable) begin
          for (int i = k - D - 1; i < k; i++) begin
            if (rq[ch][i] != rq[ch][k]) stable = 0;
          end
        end
        old = m_level[ch];
        if (stable) m_level[ch] = rq[ch][k];
        m_press[ch]   = m_level[ch] & ~old;
        m_release[ch] = ~m_level[ch] & old;
        hi_run[ch]    = m_level[ch] ? hi_run[ch] + 1 : 0;
`ifdef LONG_PRESS_EN
        m_long[ch]    = (hi_run[ch] == H + 1);
`else
        m_long[ch]    = 1'b0;
`endif
      end
    end
  end

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
  endtask

  always @(negedge clk) begin
    if (m_ready) begin
      checkOutput("model button_pressed", button_pressed, m_level);
      checkOutput("model press_pulse", press_pulse, m_press);
      checkOutput("model release_pulse", release_pulse, m_release);
      checkOutput("model any_pressed", {3'b000, any_pressed}, {3'b000, |m_level});
      checkOutput("model long_press", long_press, m_long);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] value, input int cycles);
    button = value;
    repeat (cycles) tick();
  endtask

  initial begin
    int n_press;
    int first_edge;
    int n_long;

    // Reset and idle
    #1 rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    applyStimulus(4'b0000, 20);
    checkOutput("idle level", button_pressed, 4'b0000);
    checkOutput("idle press", press_pulse, 4'b0000);
    checkOutput("idle release", release_pulse, 4'b0000);
    checkOutput("idle any", {3'b000, any_pressed}, 4'b0000);
    checkOutput("idle long", long_press, 4'b0000);

    // Clean press on ch0: level rises on edge 8
    applyStimulus(4'b0001, 7);
    checkOutput("ch0 edge7 level", button_pressed, 4'b0000);
    tick();
    checkOutput("ch0 edge8 level", button_pressed, 4'b0001);
    checkOutput("ch0 edge8 press", press_pulse, 4'b0001);
    checkOutput("ch0 edge8 any", {3'b000, any_pressed}, 4'b0001);
    tick();
    checkOutput("ch0 edge9 press", press_pulse, 4'b0000);

    // ch1 bounce then stable high
    n_press = 0;
    first_edge = 0;
    applyStimulus(4'b0011, 1);
    n_press += press_pulse[1];
    applyStimulus(4'b0001, 1);
    n_press += press_pulse[1];
    applyStimulus(4'b0011, 1);
    n_press += press_pulse[1];
    applyStimulus(4'b0001, 1);
    n_press += press_pulse[1];
    button = 4'b0011;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (press_pulse[1]) begin
        n_press++;
        if (first_edge == 0) first_edge = e;
      end
    end
    checkOutput("ch1 bounce press count", 4'(n_press), 4'd1);
    checkOutput("ch1 bounce press edge", 4'(first_edge), 4'd8);

    // 3-cycle glitch on ch2 is filtered
    n_press = 0;
    applyStimulus(4'b0111, 3);
    n_press += press_pulse[2];
    button = 4'b0011;
    for (int e = 0; e < 12; e++) begin
      tick();
      n_press += press_pulse[2];
    end
    checkOutput("ch2 glitch press count", 4'(n_press), 4'd0);
    checkOutput("ch2 glitch level", button_pressed, 4'b0011);

    // Press ch3, release ch1, then release ch0 and ch3 together
    applyStimulus(4'b1011, 10);
    applyStimulus(4'b1001, 10);
    checkOutput("pre-release level", button_pressed, 4'b1001);
    applyStimulus(4'b0000, 7);
    checkOutput("release edge7 any", {3'b000, any_pressed}, 4'b0001);
    tick();
    checkOutput("release edge8 pulse", release_pulse, 4'b1001);
    checkOutput("release edge8 press", press_pulse, 4'b0000);
    checkOutput("release edge8 any", {3'b000, any_pressed}, 4'b0000);

    // Reset mid-count with inputs held through reset
    applyStimulus(4'b0100, 12);
    checkOutput("ch2 pressed before reset", button_pressed, 4'b0100);
    applyStimulus(4'b0101, 5);
    rst = 1'b1;
    #1;
    checkOutput("reset clears level", button_pressed, 4'b0000);
    checkOutput("reset clears any", {3'b000, any_pressed}, 4'b0000);
    checkOutput("reset clears press", press_pulse, 4'b0000);
    repeat (2) tick();
    rst = 1'b0;
    repeat (7) tick();
    checkOutput("post-reset edge7 level", button_pressed, 4'b0000);
    tick();
    checkOutput("post-reset edge8 press", press_pulse, 4'b0101);
    checkOutput("post-reset edge8 level", button_pressed, 4'b0101);

    // Long press: 20 cycles after the level rise, once only
    repeat (H - 1) tick();
    checkOutput("long before hold", long_press, 4'b0000);
    tick();
    checkOutput("long at hold", long_press, LONG_EXP);
    n_long = 0;
    for (int e = 0; e < 25; e++) begin
      tick();
      n_long += long_press[2];
    end
    checkOutput("long no repeat", 4'(n_long), 4'd0);

    applyStimulus(4'b0000, 10);
    checkOutput("final level", button_pressed, 4'b0000);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
